// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S stereo receiver: data-alignment modes and
// the deserialiser state encoding.
package i2s_pkg;

  localparam int I2S_MODE_PHILIPS = 0;
  localparam int I2S_MODE_LJ      = 1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Frame buffer between the deserialiser and the consumer. Pointers carry one
// extra wrap bit so full and empty can be told apart at equal indices.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_wr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full buffer is still taken when the head leaves that cycle.
  assign w_wr    = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/i2s_rx_stereo.sv
// I2S stereo receiver: deserialises left/right slots on the bit clock and
// queues {left, right} frames for a ready/valid consumer.
//
// state | meaning
// SYNC  | waiting for the first falling WS edge, serial data discarded
// LEFT  | capturing the left slot
// RIGHT | capturing the right slot
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int MODE         = I2S_MODE_PHILIPS
) (
  input  logic                      i2s_clk,
  input  logic                      rst_n,
  input  logic                      lrcl_clk,
  input  logic                      mic_data,
  output logic [2*SAMPLE_WIDTH-1:0] data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      overflow,
  input  logic                      overflow_clr
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  i2s_state_e              r_state;
  i2s_state_e              w_state_nxt;
  logic                    r_ws_q;
  logic [CW-1:0]           r_bit_cnt;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [SAMPLE_WIDTH-1:0] r_left;
  logic                    r_overflow;
  logic [SAMPLE_WIDTH-1:0] w_shift_upd;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic [SAMPLE_WIDTH-1:0] w_msb_word;
  logic                    w_edge;
  logic                    w_room;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_drop;

  assign w_edge     = lrcl_clk ^ r_ws_q;
  assign w_room     = int'(r_bit_cnt) < SAMPLE_WIDTH;
  assign w_msb_word = {mic_data, {(SAMPLE_WIDTH-1){1'b0}}};

  // Bits are placed MSB-down by count, so a short slot leaves zero LSBs.
  always_comb begin
    w_shift_upd = r_shift;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (int'(r_bit_cnt) == SAMPLE_WIDTH - 1 - i) w_shift_upd[i] = mic_data;
    end
  end

  // Philips mode: the edge-cycle bit is still the old slot's LSB.
  assign w_word = (MODE == I2S_MODE_LJ) ? r_shift : w_shift_upd;
  assign w_push = (r_state == ST_RIGHT) && w_edge && !lrcl_clk;
  assign w_pop  = data_valid && data_ready;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SYNC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC:  if (w_edge && !lrcl_clk) w_state_nxt = ST_LEFT;
      ST_LEFT:  if (w_edge && lrcl_clk)  w_state_nxt = ST_RIGHT;
      ST_RIGHT: if (w_edge && !lrcl_clk) w_state_nxt = ST_LEFT;
      default:  w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_q    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_left    <= '0;
    end else begin
      r_ws_q <= lrcl_clk;
      if (w_edge) begin
        if (r_state == ST_LEFT) r_left <= w_word;
        if (MODE == I2S_MODE_LJ) begin
          r_shift   <= w_msb_word;
          r_bit_cnt <= CW'(1);
        end else begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end
      end else if (r_state != ST_SYNC && w_room) begin
        r_shift   <= w_shift_upd;
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (overflow_clr) r_overflow <= 1'b0;
  end

  i2s_frame_fifo #(
    .WIDTH (2*SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i2s_clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  ({r_left, w_word}),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_data  (data_out)
  );

  assign data_valid = !w_empty;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Bench for i2s_rx_stereo: a Philips 24-bit and a left-justified 16-bit
// receiver share WS and handshake; frames are predicted from the slot values.
module tb_i2s_rx_stereo;

  logic        clk;
  logic        rst_n;
  logic        lrcl;
  logic        mic0;
  logic        mic1;
  logic        rdy;
  logic        ovf_clr;
  logic [47:0] dout0;
  logic [31:0] dout1;
  logic        vld0;
  logic        vld1;
  logic        ovf0;
  logic        ovf1;

  int          n_checks;
  int          n_fail;
  int          rdy_mode;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  bit          exp_ovf0;
  bit          exp_ovf1;
  bit          pend_v;
  logic [31:0] pend_l;
  logic [31:0] pend_r;
  int          pend_len;
  logic        prev_last;
  bit          hold0;
  bit          hold1;
  logic [63:0] hold_d0;
  logic [63:0] hold_d1;

  i2s_rx_stereo #(.SAMPLE_WIDTH(24), .FIFO_DEPTH(4), .MODE(0)) u_dut0 (
    .i2s_clk(clk), .rst_n(rst_n), .lrcl_clk(lrcl), .mic_data(mic0),
    .data_out(dout0), .data_valid(vld0), .data_ready(rdy),
    .overflow(ovf0), .overflow_clr(ovf_clr)
  );

  i2s_rx_stereo #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .MODE(1)) u_dut1 (
    .i2s_clk(clk), .rst_n(rst_n), .lrcl_clk(lrcl), .mic_data(mic1),
    .data_out(dout1), .data_valid(vld1), .data_ready(rdy),
    .overflow(ovf1), .overflow_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Top sample_width bits of a len-bit slot, zero-filled when the slot is short.
  function automatic logic [31:0] exp_word(input int sw, input int len, input logic [31:0] v);
    logic [63:0] t;
    t = {32'h0, v};
    if (len >= sw) t = t >> (len - sw);
    else           t = t << (sw - len);
    t = t & ((64'h1 << sw) - 64'h1);
    return t[31:0];
  endfunction

  task automatic mon_dut(input int idx, input logic vld, input logic [63:0] d);
    logic [63:0] e;
    int          qs;
    qs = (idx == 0) ? exp_q0.size() : exp_q1.size();
    if (!vld) begin
      check_eq($sformatf("idle_zero%0d", idx), d, 64'h0);
      if (idx == 0) hold0 = 0; else hold1 = 0;
    end else begin
      if (idx == 0 && hold0) check_eq("hold_stable0", d, hold_d0);
      if (idx == 1 && hold1) check_eq("hold_stable1", d, hold_d1);
      check_eq($sformatf("valid_vs_model%0d", idx), 64'(vld), 64'(qs != 0));
      if (rdy && qs != 0) begin
        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_eq($sformatf("frame%0d", idx), d, e);
      end
      if (idx == 0) begin hold0 = !rdy; hold_d0 = d; end
      else          begin hold1 = !rdy; hold_d1 = d; end
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    mon_dut(0, vld0, {16'h0, dout0});
    mon_dut(1, vld1, {32'h0, dout1});
  end

  task automatic drive_cycle(input logic ws, input logic b0, input logic b1);
    @(negedge clk);
    lrcl = ws;
    mic0 = b0;
    mic1 = b1;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic close_pending();
    logic [31:0] w0l, w0r, w1l, w1r;
    logic [63:0] f0, f1;
    if (pend_v) begin
      w0l = exp_word(24, pend_len, pend_l);
      w0r = exp_word(24, pend_len, pend_r);
      w1l = exp_word(16, pend_len, pend_l);
      w1r = exp_word(16, pend_len, pend_r);
      f0 = (64'(w0l) << 24) | 64'(w0r);
      f1 = (64'(w1l) << 16) | 64'(w1r);
      if (exp_q0.size() < 4) exp_q0.push_back(f0); else exp_ovf0 = 1;
      if (exp_q1.size() < 4) exp_q1.push_back(f1); else exp_ovf1 = 1;
      pend_v = 0;
    end
  endtask

  // Philips stream lags by one bit; left-justified stream is aligned to WS.
  task automatic send_slot(input logic ws, input int len, input logic [31:0] v, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic b0, b1;
      b1 = v[len-1-c];
      if (c == 0) b0 = prev_last;
      else        b0 = v[len-c];
      if (c == 0 && ws == 1'b0) close_pending();
      drive_cycle(ws, b0, b1);
    end
    if (ncyc == len) prev_last = v[0];
  endtask

  task automatic send_frame(input int len, input logic [31:0] l, input logic [31:0] r);
    send_slot(1'b0, len, l, len);
    send_slot(1'b1, len, r, len);
    pend_l = l; pend_r = r; pend_len = len; pend_v = 1;
  endtask

  task automatic send_close(input int n_idle);
    close_pending();
    drive_cycle(1'b0, prev_last, 1'($urandom));
    repeat (n_idle) drive_cycle(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic preroll(input int n);
    repeat (n) drive_cycle(1'b1, 1'($urandom), 1'($urandom));
  endtask

  task automatic drain(input int max_cyc);
    rdy_mode = 1;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      drive_cycle(1'b0, 1'($urandom), 1'($urandom));
    end
    repeat (3) drive_cycle(1'b0, 1'($urandom), 1'($urandom));
    check_eq("drain_q0", 64'(exp_q0.size()), 64'h0);
    check_eq("drain_q1", 64'(exp_q1.size()), 64'h0);
    #1;
    check_eq("drain_vld0", 64'(vld0), 64'h0);
    check_eq("drain_vld1", 64'(vld1), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    lrcl  = 1'b1;
    #1;
    check_eq("rst_vld0", 64'(vld0), 64'h0);
    check_eq("rst_vld1", 64'(vld1), 64'h0);
    check_eq("rst_dout0", {16'h0, dout0}, 64'h0);
    check_eq("rst_dout1", {32'h0, dout1}, 64'h0);
    check_eq("rst_ovf0", 64'(ovf0), 64'h0);
    check_eq("rst_ovf1", 64'(ovf1), 64'h0);
    exp_q0.delete();
    exp_q1.delete();
    pend_v = 0; exp_ovf0 = 0; exp_ovf1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_ovf(input string tag);
    #1;
    check_eq({tag, "0"}, 64'(ovf0), 64'(exp_ovf0));
    check_eq({tag, "1"}, 64'(ovf1), 64'(exp_ovf1));
  endtask

  function automatic logic [31:0] rand_slot(input int len);
    logic [31:0] v;
    v = 32'($urandom);
    if (len < 32) v = v & ((32'h1 << len) - 32'h1);
    return v;
  endfunction

  initial begin
    int lens[5];
    int len;
    lens = '{16, 20, 24, 28, 32};
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; lrcl = 1'b1; mic0 = 1'b0; mic1 = 1'b0; rdy = 1'b0; ovf_clr = 1'b0;
    rdy_mode = 1; prev_last = 1'b0; pend_v = 0; hold0 = 0; hold1 = 0;
    exp_ovf0 = 0; exp_ovf1 = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed Philips frame with data_valid latency from the closing edge.
    rdy_mode = 1;
    preroll(5);
    send_frame(32, 32'hA5A5A500, 32'h12345600);
    close_pending();
    drive_cycle(1'b0, prev_last, 1'($urandom));
    #1;
    check_eq("lat_before0", 64'(vld0), 64'h0);
    check_eq("lat_before1", 64'(vld1), 64'h0);
    drive_cycle(1'b0, 1'($urandom), 1'($urandom));
    #1;
    check_eq("lat_after0", 64'(vld0), 64'h1);
    check_eq("lat_after1", 64'(vld1), 64'h1);
    drain(50);
    check_ovf("ovf_p1_");

    // Random data, random backpressure.
    do_reset();
    rdy_mode = 2;
    preroll(7);
    repeat (6) send_frame(32, 32'($urandom), 32'($urandom));
    send_close(2);
    drain(200);
    check_ovf("ovf_p2_");

    // Left-justified directed, short slots and mixed slot lengths.
    do_reset();
    rdy_mode = 1;
    preroll(3);
    send_frame(16, 32'h8001, 32'h7FFE);
    send_frame(16, 32'hBEEF, 32'hBEEF);
    repeat (6) begin
      len = lens[$urandom_range(0, 4)];
      send_frame(len, rand_slot(len), rand_slot(len));
    end
    send_close(2);
    drain(100);
    check_ovf("ovf_p3_");

    // Overflow: six frames into a four-deep buffer with no consumer.
    do_reset();
    rdy_mode = 0;
    preroll(4);
    repeat (6) send_frame(32, 32'($urandom), 32'($urandom));
    send_close(3);
    check_ovf("ovf_set_");
    drain(50);
    check_ovf("ovf_sticky_");
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    exp_ovf0 = 0; exp_ovf1 = 0;
    check_ovf("ovf_clr_");

    // Reset in the middle of a right slot, then recover.
    do_reset();
    rdy_mode = 2;
    preroll(2);
    repeat (2) send_frame(24, rand_slot(24), rand_slot(24));
    send_slot(1'b0, 24, rand_slot(24), 24);
    send_slot(1'b1, 24, rand_slot(24), 10);
    do_reset();
    rdy_mode = 1;
    preroll(9);
    repeat (3) send_frame(32, 32'($urandom), 32'($urandom));
    send_close(2);
    drain(100);
    check_ovf("ovf_p5_");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
